syscall_input_unit: RTL and testbench
=====================================

SYSCALL_INPUT_UNIT -- requirements
Module: syscall_input_unit

Interface
REQ-001 The port clk SHALL be an input, 1 bit wide, and serve as the single clock; all state SHALL update on the posedge of clk.
REQ-002 The port rst SHALL be an input, 1 bit wide, and act as a synchronous, active-high reset.
REQ-003 The port syscall_control SHALL be an input, 1 bit wide, and act as the syscall decode flag from control.
REQ-004 The port instruction SHALL be an input, 32 bits wide, and carry the current instruction; bits [5:0] are the funct code.
REQ-005 The port v0 SHALL be an input, 32 bits wide, and carry the $v0 register value that selects the service.
REQ-006 The port in_data SHALL be an input, 8 bits wide, and carry an ASCII byte from the host input stream.
REQ-007 The port in_valid SHALL be an input, 1 bit wide, and indicate that in_data is valid.
REQ-008 The port in_ready SHALL be an output, 1 bit wide, and indicate that the unit accepts a byte this cycle.
REQ-009 The port stall SHALL be an output, 1 bit wide, and freeze the pipeline while a read service is in progress.
REQ-010 The port reg_write_en SHALL be an output, 1 bit wide, and act as the register-file write strobe for the result.
REQ-011 The port reg_write_addr SHALL be an output, 5 bits wide, and carry the register-file write address.
REQ-012 The port reg_write_data SHALL be an output, 32 bits wide, and carry the result written to $v0.
REQ-013 The port read_count SHALL be an output, 16 bits wide, and count completed read services.

Function
REQ-014 The trigger condition SHALL be: syscall_control=1, instruction[5:0]=6'h0c, v0 equal to 5 (read_int) or 12 (read_char), and the state is IDLE.
REQ-015 Other v0 values SHALL be ignored, with no stall and no write, and left to the output syscall path.
REQ-016 A trigger SHALL capture the service type and move to WAIT_CHAR (v0=12) or PARSE_INT (v0=5) on the next edge.
REQ-017 The FSM SHALL have exactly four states: IDLE, WAIT_CHAR, PARSE_INT and WRITEBACK.
REQ-018 stall SHALL be combinational: 1 when the trigger condition holds in IDLE, and 1 in every non-IDLE state including WRITEBACK.
REQ-019 in_ready SHALL be 1 only in WAIT_CHAR and PARSE_INT; a byte transfers only on a cycle with in_valid=1 and in_ready=1.
REQ-020 In WAIT_CHAR, a transferred byte SHALL become the zero-extended result, followed by a move to WRITEBACK.
REQ-021 In PARSE_INT, leading 0x20 bytes before any sign or digit SHALL be discarded.
REQ-022 In PARSE_INT, a '-' (0x2D) that is the first non-space byte SHALL set the negative flag; any later '-' SHALL act as a terminator.
REQ-023 In PARSE_INT, each digit 0x30-0x39 SHALL update acc = acc*10 + digit, computed modulo 2^32 with wrap and no saturation.
REQ-024 In PARSE_INT, any other byte (for example 0x0A) SHALL be consumed as the terminator, followed by a move to WRITEBACK.
REQ-025 On terminator, the result SHALL be acc when the negative flag is clear and (~acc+1) mod 2^32 when it is set.
REQ-026 A terminator with no digits received SHALL produce the result 0, including the "-\n" input.
REQ-027 WRITEBACK SHALL last exactly one cycle: reg_write_en=1, reg_write_addr=5'd2, reg_write_data=result, and read_count incremented mod 2^16.
REQ-028 After WRITEBACK the FSM SHALL return to IDLE, with acc and the negative flag cleared.
REQ-029 reg_write_en SHALL be 0 outside WRITEBACK, and reg_write_data SHALL be 0 outside WRITEBACK.
REQ-030 A trigger condition present while the FSM is not IDLE SHALL be ignored.
REQ-031 in_valid=0 SHALL hold the state indefinitely, with stall held at 1 and no timeout.
REQ-032 Minimum latency SHALL be: trigger cycle, plus one byte per transfer cycle, plus the WRITEBACK cycle; read_char with in_valid already 1 SHALL reach WRITEBACK 2 edges after the trigger.

Reset
REQ-033 While rst=1 at a posedge, the state SHALL become IDLE, acc and the negative flag 0, and read_count 0.
REQ-034 While rst=1, in_ready, reg_write_en, reg_write_addr and reg_write_data SHALL all be 0.
REQ-035 Reset during WAIT_CHAR, PARSE_INT or WRITEBACK SHALL abandon the service, with no register write after reset.
REQ-036 stall SHALL be 0 in the cycle after reset unless a new trigger is present.

Verification
REQ-037 Read_char test: trigger with v0=12 and in_data=0x41 held valid -> exactly one write, addr 2, data 0x00000041; read_count=1.
REQ-038 Read_int parse test: v0=5 with stream " 123\n" -> data 0x0000007B; stall=1 from the trigger cycle through WRITEBACK, then 0.
REQ-039 Negative and empty-input test: stream "-45\n" -> data 0xFFFFFFD3; stream "\n" -> data 0.
REQ-040 Wrap test: stream "4294967297\n" -> data 0x00000001; in_valid gaps of 3 cycles inserted -> same result, with stall held throughout.
REQ-041 Ignore-and-reset test: v0=1 or v0=10 syscall -> no stall and no write; rst asserted mid-"987" -> no write, read_count=0, and stall=0 the next cycle.

Source files
------------

// File: rtl/syscall_input_if.sv
// Syscall input unit bus: decode inputs from the pipeline, host byte stream
// handshake, and register-file writeback outputs.
//   slave  : the unit side (decode/stream in, ready/stall/writeback out)
//   master : the pipeline/host side
interface syscall_input_if;
   logic        syscall_control;
   logic [31:0] instruction;
   logic [31:0] v0;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        stall;
   logic        reg_write_en;
   logic [4:0]  reg_write_addr;
   logic [31:0] reg_write_data;
   logic [15:0] read_count;

   modport slave (
      input  syscall_control, instruction, v0, in_data, in_valid,
      output in_ready, stall, reg_write_en, reg_write_addr, reg_write_data, read_count
   );

   modport master (
      output syscall_control, instruction, v0, in_data, in_valid,
      input  in_ready, stall, reg_write_en, reg_write_addr, reg_write_data, read_count
   );
endinterface

// File: rtl/syscall_input_unit.sv
// Syscall input unit: services read_int (v0=5) and read_char (v0=12) syscalls
// by consuming ASCII bytes from the host stream, stalling the pipeline until
// the result is written back to $v0.
// Ports:
//   clk  - clock, all state updates on posedge
//   rst  - synchronous active-high reset
//   bus  - syscall_input_if.slave: syscall_control/instruction/v0 decode inputs,
//          in_data/in_valid/in_ready byte stream, stall (combinational),
//          reg_write_en/addr/data writeback, read_count completed services
module syscall_input_unit (
   input  logic            clk,
   input  logic            rst,
   syscall_input_if.slave  bus
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned ADDR_W = 5;

   localparam logic [5:0]        FUNCT_SYSCALL = 6'h0c;
   localparam logic [DATA_W-1:0] SVC_READ_INT  = DATA_W'(5);
   localparam logic [DATA_W-1:0] SVC_READ_CHAR = DATA_W'(12);
   localparam logic [ADDR_W-1:0] V0_ADDR       = ADDR_W'(2);
   localparam logic [BYTE_W-1:0] CH_SPACE      = 8'h20;
   localparam logic [BYTE_W-1:0] CH_MINUS      = 8'h2D;
   localparam logic [BYTE_W-1:0] CH_ZERO       = 8'h30;
   localparam logic [BYTE_W-1:0] CH_NINE       = 8'h39;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_CHAR = 2'd1,
      PARSE_INT = 2'd2,
      WRITEBACK = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic                neg_q, neg_d;
   // set once a sign or digit has been seen; later spaces/'-' terminate
   logic                started_q, started_d;
   logic [CNT_W-1:0]    count_q, count_d;

   logic                svc_match_c;
   logic                trigger_c;
   logic                xfer_c;
   logic                is_digit_c;

   // Decode of a read service syscall, only honoured from IDLE
   assign svc_match_c = bus.syscall_control &&
                        (bus.instruction[5:0] == FUNCT_SYSCALL) &&
                        ((bus.v0 == SVC_READ_INT) || (bus.v0 == SVC_READ_CHAR));
   assign trigger_c   = svc_match_c && (state_q == IDLE);
   assign xfer_c      = bus.in_valid && bus.in_ready;
   assign is_digit_c  = (bus.in_data >= CH_ZERO) && (bus.in_data <= CH_NINE);

   // Outputs decoded from state; forced low while reset is held
   assign bus.in_ready       = !rst && ((state_q == WAIT_CHAR) || (state_q == PARSE_INT));
   assign bus.reg_write_en   = !rst && (state_q == WRITEBACK);
   assign bus.reg_write_addr = (!rst && (state_q == WRITEBACK)) ? V0_ADDR : '0;
   assign bus.reg_write_data = (!rst && (state_q == WRITEBACK)) ? result_q : '0;
   assign bus.read_count     = count_q;
   // Stall must cover the trigger cycle itself so the pipeline freezes at once
   assign bus.stall          = trigger_c || (state_q != IDLE);

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         result_q  <= '0;
         neg_q     <= 1'b0;
         started_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         result_q  <= result_d;
         neg_q     <= neg_d;
         started_q <= started_d;
         count_q   <= count_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      result_d  = result_q;
      neg_d     = neg_q;
      started_d = started_q;
      count_d   = count_q;

      case (state_q)
         IDLE: begin
            acc_d     = '0;
            neg_d     = 1'b0;
            started_d = 1'b0;
            if (trigger_c) begin
               state_d = (bus.v0 == SVC_READ_CHAR) ? WAIT_CHAR : PARSE_INT;
            end
         end

         WAIT_CHAR: begin
            if (xfer_c) begin
               result_d = DATA_W'(bus.in_data);
               state_d  = WRITEBACK;
            end
         end

         PARSE_INT: begin
            if (xfer_c) begin
               if (!started_q && (bus.in_data == CH_SPACE)) begin
                  started_d = 1'b0;
               end else if (!started_q && (bus.in_data == CH_MINUS)) begin
                  neg_d     = 1'b1;
                  started_d = 1'b1;
               end else if (is_digit_c) begin
                  // wraps modulo 2^32 by construction of the 32-bit product
                  acc_d     = (acc_q * DATA_W'(10)) + DATA_W'(bus.in_data[3:0]);
                  started_d = 1'b1;
               end else begin
                  result_d = neg_q ? (~acc_q + DATA_W'(1)) : acc_q;
                  state_d  = WRITEBACK;
               end
            end
         end

         WRITEBACK: begin
            count_d   = count_q + CNT_W'(1);
            acc_d     = '0;
            neg_d     = 1'b0;
            started_d = 1'b0;
            result_d  = '0;
            state_d   = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_syscall_input_unit.sv
// Bench for syscall_input_unit: directed and randomized read_char/read_int
// services checked against a number-level reference model.
module tb_syscall_input_unit;
   typedef logic [7:0] bq_t[$];

   logic clk;
   logic rst;
   int   total;
   int   bad;
   logic [15:0] exp_count;

   syscall_input_if bus ();

   syscall_input_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bq_t str2q(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
      return q;
   endfunction

   // Drives one syscall and its byte stream, inserting gap idle cycles after
   // every accepted byte; reports what the unit did.
   task automatic run_service(input logic [31:0] v0v, input bq_t bytes, input int gap,
                              output logic [31:0] data, output int writes, output int lat,
                              output bit stall_ok, output bit addr_ok, output bit stall_after,
                              output logic [15:0] cnt_after, output bit timeout);
      int idx;
      int gcnt;
      int k;
      bit done;
      idx = 0; gcnt = 0; k = 0; done = 1'b0;
      writes = 0; data = '0; lat = -1; stall_ok = 1'b1; addr_ok = 1'b1; timeout = 1'b0;
      @(negedge clk);
      bus.syscall_control = 1'b1;
      bus.instruction     = 32'h0000_000c;
      bus.v0              = v0v;
      if (gap == 0 && bytes.size() > 0) begin
         bus.in_valid = 1'b1;
         bus.in_data  = bytes[0];
      end else begin
         bus.in_valid = 1'b0;
      end
      #1;
      if (bus.stall !== 1'b1) stall_ok = 1'b0;
      while (!done && k < 2000) begin
         @(negedge clk);
         k++;
         bus.syscall_control = 1'b0;
         if (gcnt > 0) begin
            bus.in_valid = 1'b0;
            gcnt--;
         end else if (idx < bytes.size()) begin
            bus.in_valid = 1'b1;
            bus.in_data  = bytes[idx];
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         if (bus.stall !== 1'b1) stall_ok = 1'b0;
         if (bus.reg_write_en === 1'b1) begin
            writes++;
            data = bus.reg_write_data;
            if (bus.reg_write_addr !== 5'd2) addr_ok = 1'b0;
            lat  = k;
            done = 1'b1;
         end else if (bus.in_valid && bus.in_ready) begin
            idx++;
            gcnt = gap;
         end
      end
      timeout = !done;
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      stall_after = bus.stall;
      if (bus.reg_write_en === 1'b1) writes++;
      cnt_after = bus.read_count;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.syscall_control = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h41;
      @(negedge clk);
      #1;
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
      total++; if (bus.reg_write_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b want=0", bus.reg_write_en); end
      total++; if (bus.reg_write_addr !== 5'd0 || bus.reg_write_data !== 32'd0) begin bad++; $display("FAIL reset_wr_bus got=%h/%h want=0/0", bus.reg_write_addr, bus.reg_write_data); end
      @(negedge clk);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", bus.stall); end
      total++; if (bus.read_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.read_count); end
      exp_count = 16'd0;
   endtask

   task automatic test_read_char();
      logic [31:0] d; int w; int lat; bit sok; bit aok; bit sa; logic [15:0] c; bit to;
      run_service(32'd12, str2q("A"), 0, d, w, lat, sok, aok, sa, c, to);
      exp_count++;
      total++; if (d !== 32'h41 || w !== 1 || !aok) begin bad++; $display("FAIL read_char data=%h writes=%0d addr_ok=%0d want=00000041/1/1", d, w, aok); end
      total++; if (lat !== 2) begin bad++; $display("FAIL read_char_latency got=%0d want=2", lat); end
      total++; if (c !== exp_count) begin bad++; $display("FAIL read_char_count got=%0d want=%0d", c, exp_count); end
      total++; if (!sok || sa !== 1'b0 || to) begin bad++; $display("FAIL read_char_stall during=%0d after=%b timeout=%0d", sok, sa, to); end
   endtask

   task automatic test_read_int();
      logic [31:0] d; int w; int lat; bit sok; bit aok; bit sa; logic [15:0] c; bit to;
      run_service(32'd5, str2q(" 123\n"), 0, d, w, lat, sok, aok, sa, c, to);
      exp_count++;
      total++; if (d !== 32'h7B || w !== 1 || !aok) begin bad++; $display("FAIL read_int_123 data=%h writes=%0d want=0000007b/1", d, w); end
      total++; if (!sok || sa !== 1'b0) begin bad++; $display("FAIL read_int_stall during=%0d after=%b want=1/0", sok, sa); end
      total++; if (c !== exp_count) begin bad++; $display("FAIL read_int_count got=%0d want=%0d", c, exp_count); end
   endtask

   task automatic test_negative_empty();
      logic [31:0] d; int w; int lat; bit sok; bit aok; bit sa; logic [15:0] c; bit to;
      run_service(32'd5, str2q("-45\n"), 0, d, w, lat, sok, aok, sa, c, to);
      exp_count++;
      total++; if (d !== 32'hFFFF_FFD3 || w !== 1) begin bad++; $display("FAIL neg45 data=%h writes=%0d want=ffffffd3/1", d, w); end
      run_service(32'd5, str2q("\n"), 0, d, w, lat, sok, aok, sa, c, to);
      exp_count++;
      total++; if (d !== 32'd0 || w !== 1) begin bad++; $display("FAIL empty data=%h writes=%0d want=0/1", d, w); end
      run_service(32'd5, str2q("-\n"), 0, d, w, lat, sok, aok, sa, c, to);
      exp_count++;
      total++; if (d !== 32'd0 || w !== 1) begin bad++; $display("FAIL minus_only data=%h writes=%0d want=0/1", d, w); end
      run_service(32'd5, str2q("7-3\n"), 0, d, w, lat, sok, aok, sa, c, to);
      exp_count++;
      total++; if (d !== 32'd7 || c !== exp_count) begin bad++; $display("FAIL late_minus data=%h count=%0d want=7/%0d", d, c, exp_count); end
   endtask

   task automatic test_wrap_gaps();
      logic [31:0] d; int w; int lat; bit sok; bit aok; bit sa; logic [15:0] c; bit to;
      run_service(32'd5, str2q("4294967297\n"), 0, d, w, lat, sok, aok, sa, c, to);
      exp_count++;
      total++; if (d !== 32'd1 || w !== 1) begin bad++; $display("FAIL wrap data=%h writes=%0d want=1/1", d, w); end
      run_service(32'd5, str2q("4294967297\n"), 3, d, w, lat, sok, aok, sa, c, to);
      exp_count++;
      total++; if (d !== 32'd1 || w !== 1 || to) begin bad++; $display("FAIL wrap_gap data=%h writes=%0d timeout=%0d want=1/1/0", d, w, to); end
      total++; if (!sok || sa !== 1'b0) begin bad++; $display("FAIL wrap_gap_stall during=%0d after=%b want=1/0", sok, sa); end
   endtask

   task automatic test_ignore();
      logic [31:0] vals[3];
      bit quiet;
      vals[0] = 32'd1; vals[1] = 32'd10; vals[2] = 32'd5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.syscall_control = 1'b1;
         bus.v0 = vals[i];
         // the third case is read_int but with a non-syscall funct code
         bus.instruction = (i == 2) ? 32'h0000_0020 : 32'h0000_000c;
         bus.in_valid = 1'b1;
         bus.in_data  = 8'h35;
         #1;
         total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL ignore_stall v0=%0d got=%b want=0", vals[i], bus.stall); end
         quiet = 1'b1;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            if (bus.reg_write_en !== 1'b0 || bus.in_ready !== 1'b0 || bus.stall !== 1'b0) quiet = 1'b0;
         end
         total++; if (!quiet) begin bad++; $display("FAIL ignore_quiet v0=%0d got=0 want=1", vals[i]); end
         bus.syscall_control = 1'b0;
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      bit quiet;
      @(negedge clk);
      bus.syscall_control = 1'b1;
      bus.instruction = 32'h0000_000c;
      bus.v0 = 32'd5;
      bus.in_valid = 1'b1;
      bus.in_data = 8'h39;
      @(negedge clk);
      bus.syscall_control = 1'b0;
      @(negedge clk);
      bus.in_data = 8'h38;
      @(negedge clk);
      rst = 1'b1;
      bus.in_data = 8'h37;
      #1;
      total++; if (bus.in_ready !== 1'b0 || bus.reg_write_en !== 1'b0 || bus.reg_write_data !== 32'd0) begin bad++; $display("FAIL midrst_outputs ready=%b en=%b data=%h want=0/0/0", bus.in_ready, bus.reg_write_en, bus.reg_write_data); end
      @(negedge clk);
      rst = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = 8'h0A;
      #1;
      exp_count = 16'd0;
      total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL midrst_stall got=%b want=0", bus.stall); end
      total++; if (bus.read_count !== exp_count) begin bad++; $display("FAIL midrst_count got=%0d want=0", bus.read_count); end
      quiet = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         if (bus.reg_write_en !== 1'b0 || bus.stall !== 1'b0) quiet = 1'b0;
      end
      bus.in_valid = 1'b0;
      total++; if (!quiet) begin bad++; $display("FAIL midrst_no_write got=0 want=1"); end
   endtask

   // Random services: expected value comes from the number itself, not the bytes
   task automatic test_random();
      logic [31:0] d; int w; int lat; bit sok; bit aok; bit sa; logic [15:0] c; bit to;
      longint unsigned m;
      logic [31:0] mag;
      logic [31:0] expv;
      logic [7:0] terms[4];
      bit neg;
      string s;
      bq_t q;
      terms[0] = 8'h0A; terms[1] = 8'h20; terms[2] = 8'h2C; terms[3] = 8'h2D;
      for (int it = 0; it < 14; it++) begin
         if (it % 5 == 4) begin
            mag = 32'($urandom_range(32, 126));
            q = {};
            q.push_back(mag[7:0]);
            expv = mag;
            run_service(32'd12, q, $urandom_range(0, 2), d, w, lat, sok, aok, sa, c, to);
         end else begin
            if ($urandom % 2 == 1) m = longint'($urandom_range(0, 999));
            else m = {32'($urandom), 32'($urandom)} % 64'd100000000000;
            neg = 1'($urandom % 2);
            mag = m[31:0];
            expv = neg ? (32'd0 - mag) : mag;
            s = "";
            for (int sp = 0; sp < int'($urandom_range(0, 2)); sp++) s = {s, " "};
            if (neg) s = {s, "-"};
            s = {s, $sformatf("%0d", m)};
            q = str2q(s);
            q.push_back(terms[$urandom_range(0, 3)]);
            run_service(32'd5, q, $urandom_range(0, 2), d, w, lat, sok, aok, sa, c, to);
         end
         exp_count++;
         total++; if (d !== expv || w !== 1 || !aok || to) begin bad++; $display("FAIL random_%0d data=%h writes=%0d timeout=%0d want=%h/1/0", it, d, w, to, expv); end
         total++; if (c !== exp_count || !sok || sa !== 1'b0) begin bad++; $display("FAIL random_%0d_side count=%0d stall_ok=%0d after=%b want=%0d/1/0", it, c, sok, sa, exp_count); end
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      exp_count = 16'd0;
      rst = 1'b1;
      bus.syscall_control = 1'b0;
      bus.instruction = 32'd0;
      bus.v0 = 32'd0;
      bus.in_data = 8'd0;
      bus.in_valid = 1'b0;
      test_reset();
      test_read_char();
      test_read_int();
      test_negative_empty();
      test_wrap_gaps();
      test_ignore();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
